// File: rtl/tdm_demux_pkg.sv
// tdm_pkg: shared types and frame geometry for the TDM demultiplexer.
// Build option: TDM_DEMUX_PARITY_EN adds one even-parity slot per frame.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME_EXTRA = 1;
`else
    localparam int FRAME_EXTRA = 0;
`endif

    // Slots per frame on the wire: data slots plus the optional parity slot.
    function automatic int frame_len(input int n);
        return n + FRAME_EXTRA;
    endfunction

    // Width of the slot index for a frame of n data slots.
    function automatic int slot_w(input int n);
        return $clog2(n + FRAME_EXTRA);
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial-in / parallel-out bundle of the TDM receiver.
// Build option: TDM_DEMUX_PARITY_EN widens slot by way of tdm_pkg::slot_w.
interface tdm_demux_if #(
    parameter int N = 8
);
    localparam int SW = tdm_pkg::slot_w(N);

    logic          en;
    logic          sin;
    logic          sync;
    logic [N-1:0]  y;
    logic          valid;
    logic [SW-1:0] slot;
    logic          locked;
    logic          err;

    modport master (output en, sin, sync, input y, valid, slot, locked, err);
    modport slave  (input en, sin, sync, output y, valid, slot, locked, err);
endinterface

// File: rtl/tdm_demux_slot_counter.sv
// slot_counter: modulo-MOD counter. A strobe with load0 marks the current
// strobe as slot 0, so the counter moves to 1 rather than clearing.
module slot_counter #(
    parameter int MOD = 8,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load0,
    output logic [W-1:0] count
);

    // Advance on each strobe, wrapping MOD-1 -> 0; load0 realigns to slot 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (load0) begin
                count <= W'(1);
            end else if (count == W'(MOD - 1)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds an N-bit word from a slot-multiplexed serial stream.
// Build option: TDM_DEMUX_PARITY_EN checks an extra even-parity slot and
// drops frames whose parity is wrong.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        reset,
    tdm_demux_if.slave  bus
);

    localparam int FL = frame_len(N);
    localparam int SW = slot_w(N);

    tdm_state_t    state;
    logic [N-1:0]  shadow;
    logic [N-1:0]  shadow_next;
    logic [N-1:0]  word;
    logic          valid_pulse;
    logic          err_pulse;
    logic [SW-1:0] slot;
    logic          cnt_en;
    logic          last_slot;

    // The counter only moves on strobes that are kept: an accepted sync in
    // HUNT, or any strobe in LOCKED except a slot 0 that lost its sync.
    always_comb begin
        cnt_en = 1'b0;
        if (bus.en) begin
            if (state == HUNT) begin
                cnt_en = bus.sync;
            end else begin
                cnt_en = !((slot == '0) && !bus.sync);
            end
        end
    end

    slot_counter #(
        .MOD (FL),
        .W   (SW)
    ) u_slot (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .load0 (bus.sync),
        .count (slot)
    );

    // Shadow with the current serial bit dropped into its slot position.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < N; k++) begin
            if (slot == SW'(k)) begin
                shadow_next[k] = bus.sin;
            end
        end
    end

    assign last_slot = (slot == SW'(FL - 1));

    // Frame FSM, shadow capture, output word and strobe generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            shadow      <= '0;
            word        <= '0;
            valid_pulse <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            if (bus.en) begin
                if (state == HUNT) begin
                    if (bus.sync) begin
                        shadow[0] <= bus.sin;
                        state     <= LOCKED;
                    end
                end else if (bus.sync && (slot != '0)) begin
                    // Misaligned sync: restart the frame on this strobe.
                    shadow[0] <= bus.sin;
                    err_pulse <= 1'b1;
                end else if (!bus.sync && (slot == '0)) begin
                    // Sync lost: discard this bit and search again.
                    state     <= HUNT;
                    err_pulse <= 1'b1;
                end else begin
                    shadow <= shadow_next;
                    if (last_slot) begin
`ifdef TDM_DEMUX_PARITY_EN
                        // Even parity: data bits plus parity bit xor to 0.
                        if (((^shadow) ^ bus.sin) == 1'b0) begin
                            word        <= shadow;
                            valid_pulse <= 1'b1;
                        end else begin
                            err_pulse   <= 1'b1;
                        end
`else
                        word        <= shadow_next;
                        valid_pulse <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign bus.y      = word;
    assign bus.valid  = valid_pulse;
    assign bus.slot   = slot;
    assign bus.locked = (state == LOCKED);
    assign bus.err    = err_pulse;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive end of the team's mux-based time-division link. The transmitter is a `muxN` whose select line is driven by a slot counter. This block takes the resulting serial stream plus a frame-sync marker and rebuilds the N-bit parallel word, so that slot k lands in output bit k. It sits directly after the link, one clock domain, and feeds a registered word with a one-cycle valid strobe to downstream logic.

## Interface
- `N`, default 8: slots per frame, i.e. width of the rebuilt word. Must be ≥ 2.
- `SW`, default `$clog2(N)`: slot index width. Derived; do not override.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: bit strobe. `sin` and `sync` are sampled only on cycles with `en`=1.
- `sin` input 1: serial data; one slot per `en` cycle.
- `sync` input 1: frame marker, asserted with `en` on slot 0.
- `y` output N: last complete frame; `y[k]` = bit received in slot k.
- `valid` output 1: one-cycle pulse when `y` is updated.
- `slot` output SW: index the next `en` cycle will be written to.
- `locked` output 1: frame alignment established.
- `err` output 1: one-cycle pulse on a framing error.

## Operation
- States: `HUNT`, `LOCKED`.
- Reset: state `HUNT`. `y`=0, shadow=0, `slot`=0, `valid`=0, `locked`=0, `err`=0.
- `HUNT`:
  - `en` cycles without `sync` are discarded.
  - On `en & sync`: shadow[0]←`sin`, `slot`←1, go `LOCKED`.
- `LOCKED`:
  - On each `en` cycle, shadow[`slot`]←`sin`.
  - `slot` increments and wraps N-1→0.
  - On the capture of slot N-1: `y`←{`sin`, shadow[N-2:0]}, then pulse `valid`.
- Framing errors (both pulse `err` for one cycle):
  - `en & sync` when `slot`≠0: the frame is misaligned. Discard the partial frame and treat the cycle as slot 0: shadow[0]←`sin`, `slot`←1, stay `LOCKED`, no `valid`.
  - `en & ~sync` when `slot`=0: sync was lost. Discard the bit, go `HUNT`, `slot`←0, `locked`←0.
- `en`=0: hold all state. `valid` and `err` are 0.
- `locked` = (state==`LOCKED`).
- `y` holds its value between frames and is never cleared except by `reset`.

## Timing
- All outputs are registered.
- `valid` and the new `y` appear on the clock edge that samples slot N-1. `valid` is high for exactly the following cycle.
- Latency: 1 clock from the last-slot `en` cycle to `valid`.
- `err` is high the cycle after the offending `en` cycle.
- `locked` rises the cycle after the sync that is accepted.
- Back-to-back frames with `en` held high sustain `valid` once every N cycles with no gap cycles.
- `reset` has priority over everything. Reset mid-frame drops the partial frame, and the next cycle shows reset values.
- `sync` asserted with `en`=0 is ignored.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - Each frame carries an extra slot N holding even parity over slots 0..N-1. The slot counter runs 0..N.
  - On capturing slot N, if parity matches: update `y` and pulse `valid`.
  - If parity mismatches: leave `y` unchanged, suppress `valid`, pulse `err`, stay `LOCKED`.
  - `SW` becomes `$clog2(N+1)`.
- `TDM_DEMUX_PARITY_EN` undefined: no parity slot. Behaviour is exactly as above.

## Structure
- Package `tdm_pkg`:
  - `typedef enum logic {HUNT, LOCKED} tdm_state_t`
  - a `localparam` for the frame length (N or N+1 depending on the macro), derived from the macro.
- Sub-module `slot_counter`: a parameterised modulo counter with `clk`, `reset`, `en`, `load0`, and `count`. The demux instantiates it to drive `slot`.
- The demux keeps the FSM, the shadow register, the output register and the error logic.

## Test plan
- Aligned frame: N=8, send 8'b10101100 LSB-first (slot0=0, slot1=0, slot2=1, slot3=1, slot4=0, slot5=1, slot6=0, slot7=1), `sync` on slot 0, `en`=1. Expect `y`=8'hAC, one `valid` pulse, `locked`=1, `err`=0.
- Hunt discard: 5 `en` bits with no `sync`, then an aligned 8'h5A frame. Expect no `valid` and `locked`=0 until sync. Then `y`=8'h5A with exactly one `valid`.
- Gapped strobe: the 8'hC3 frame with `en` high every third cycle. Expect `y`=8'hC3, `valid` one cycle wide, nothing changes on `en`=0 cycles.
- Misplaced sync: `sync` at slot 4 mid-frame, then 8 clean bits of 8'h0F. Expect an `err` pulse, no `valid` for the broken frame, then `y`=8'h0F.
- Lost sync and reset: a frame 8'hFF, then slot 0 arrives without `sync`. Expect `err`, `locked`=0, `y` still 8'hFF. Then assert `reset` at slot 3 of the next frame and expect all outputs 0 on the following cycle.
- With `TDM_DEMUX_PARITY_EN`:
  - 8'hAC plus parity bit 0: expect `valid` and `y`=8'hAC.
  - 8'hAC plus parity bit 1: expect `err`, no `valid`, `y` unchanged.
